// File: rtl/mc8051_mem_seq_if.sv
// Bus bundle between the mc8051 control/operand logic, the memory sequencer and the memory bus.
// The slave modport is the sequencer's view; the master modport is the view of whatever drives it.
interface mc8051_mem_seq_if;
    // request side, from the control unit and operand multiplexer
    logic        i_mem_req;
    logic        i_mem_wr;
    logic [1:0]  i_mem_space;
    logic        i_buf_sel;
    logic [15:0] i_mem_addr_d;
    logic [7:0]  i_mem_wdata;

    // bus return path
    logic [7:0]  i_mem_rdata;
    logic        i_mem_ready;

    // sequencer outputs
    logic [15:0] o_mem_addr;
    logic [7:0]  o_mem_wdata;
    logic [1:0]  o_mem_space;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic [7:0]  o_s2_data_buf;
    logic [7:0]  o_s3_data_buf;
    logic        o_busy;
    logic        o_mem_done;
    logic        o_bus_err;

    modport slave (
        input  i_mem_req, i_mem_wr, i_mem_space, i_buf_sel, i_mem_addr_d, i_mem_wdata,
        input  i_mem_rdata, i_mem_ready,
        output o_mem_addr, o_mem_wdata, o_mem_space, o_mem_rd, o_mem_wr,
        output o_s2_data_buf, o_s3_data_buf, o_busy, o_mem_done, o_bus_err
    );

    modport master (
        output i_mem_req, i_mem_wr, i_mem_space, i_buf_sel, i_mem_addr_d, i_mem_wdata,
        output i_mem_rdata, i_mem_ready,
        input  o_mem_addr, o_mem_wdata, o_mem_space, o_mem_rd, o_mem_wr,
        input  o_s2_data_buf, o_s3_data_buf, o_busy, o_mem_done, o_bus_err
    );
endinterface

// File: rtl/mc8051_mem_seq.sv
// mc8051 memory access sequencer: one bus transaction at a time with ready handshake and
// wait-state timeout, loading read results into the S2/S3 operand buffers.
module mc8051_mem_seq #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic               i_clk,
    input logic               i_rst,
    mc8051_mem_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Last wait-counter value before abort: the strobe stays up for exactly TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_next;

    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [1:0]  space_q;
    logic        wr_q;
    logic        sel_q;
    logic        err_q;
    logic [7:0]  cnt_q;
    logic [7:0]  s2_q;
    logic [7:0]  s3_q;

    logic        accept;
    logic        finish;
    logic        abort;
    logic        load_buf;
    logic [7:0]  load_data;

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_mem_req) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // Ready wins over a simultaneous timeout count.
                if (bus.i_mem_ready) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.i_mem_req) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign load_buf  = (finish | abort) & ~wr_q;
    assign load_data = finish ? bus.i_mem_rdata : 8'hFF;

    // NOTE: sequential state uses non-blocking assignments only, so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            space_q <= 2'b00;
            wr_q    <= 1'b0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h00;
            s2_q    <= 8'h00;
            s3_q    <= 8'h00;
        end else begin
            if (accept) begin
                addr_q  <= bus.i_mem_addr_d;
                wdata_q <= bus.i_mem_wdata;
                space_q <= bus.i_mem_space;
                wr_q    <= bus.i_mem_wr;
                sel_q   <= bus.i_buf_sel;
                err_q   <= 1'b0;
                cnt_q   <= 8'h00;
            end else if ((state == ACCESS) && !bus.i_mem_ready) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (abort) begin
                err_q <= 1'b1;
            end

            if (load_buf) begin
                if (sel_q) begin
                    s3_q <= load_data;
                end else begin
                    s2_q <= load_data;
                end
            end
        end
    end

    // Strobes and status decode from registered state only; busy also looks at a pending request.
    assign bus.o_mem_addr    = addr_q;
    assign bus.o_mem_wdata   = wdata_q;
    assign bus.o_mem_space   = space_q;
    assign bus.o_mem_rd      = (state == ACCESS) & ~wr_q;
    assign bus.o_mem_wr      = (state == ACCESS) &  wr_q;
    assign bus.o_s2_data_buf = s2_q;
    assign bus.o_s3_data_buf = s3_q;
    assign bus.o_busy        = (state == ACCESS) | ((state == DONE) & bus.i_mem_req);
    assign bus.o_mem_done    = (state == DONE);
    assign bus.o_bus_err     = (state == DONE) & err_q;

endmodule
